// File: rtl/adc_channel_averager.sv
// rtl/adc_channel_averager.sv - periodic snapshot of the ADC channel bus with per-channel EMA, streamed out one channel per beat
// Optional feature macro: ADC_FILT_ALARM_EN (per-channel threshold alarm on the filtered value)
module adc_channel_averager #(
  parameter int NUM_CH     = 13,
  parameter int SHIFT      = 3,
  parameter int SAMPLE_DIV = 79300
`ifdef ADC_FILT_ALARM_EN
  , parameter int ALARM_LEVEL = 3000
`endif
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_CH*12-1:0] ch_bus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_ch,
  output logic [11:0]          out_data,
  output logic                 sweep_done,
  output logic                 overrun
`ifdef ADC_FILT_ALARM_EN
  , output logic [NUM_CH-1:0]  alarm
`endif
);
  localparam int AW = 12 + SHIFT;
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [3:0] LAST = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, FILTER, EMIT} state_t;
  state_t state, state_next;

  logic [CW-1:0]        cnt;
  logic                 tick;
  logic [NUM_CH*12-1:0] snap;
  logic [AW-1:0]        acc [NUM_CH];
  logic [3:0]           idx;
  logic                 init;
  logic [11:0]          x;
  logic [AW-1:0]        acc_cur;
  logic [AW-1:0]        acc_new;
  logic                 hs;

  assign tick = (cnt == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge clock or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_ch     = 4'd0;
    out_data   = 12'd0;
    hs         = 1'b0;
    case (state)
      IDLE:    if (tick) state_next = CAPTURE;
      CAPTURE: state_next = FILTER;
      FILTER:  if (idx == LAST) state_next = EMIT;
      EMIT: begin
        // Outputs come only from registered state, so ready never feeds valid
        out_valid = 1'b1;
        out_ch    = idx;
        out_data  = 12'(acc_cur >> SHIFT);
        hs        = out_ready;
        if (out_ready && idx == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign x       = snap[idx*12 +: 12];
  assign acc_cur = acc[idx];
  // Steady-state update stays within 4095<<SHIFT, so no saturation is needed
  assign acc_new = init ? (AW'(x) << SHIFT) : (acc_cur - (acc_cur >> SHIFT) + AW'(x));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      idx        <= 4'd0;
      init       <= 1'b1;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else begin
      sweep_done <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        CAPTURE: begin
          snap <= ch_bus;
          idx  <= 4'd0;
        end
        FILTER: begin
          acc[idx] <= acc_new;
          if (idx == LAST) begin
            idx  <= 4'd0;
            init <= 1'b0;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        EMIT: begin
          if (hs) begin
            if (idx == LAST) begin
              idx        <= 4'd0;
              sweep_done <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADC_FILT_ALARM_EN
  logic [11:0] new_out;
  assign new_out = 12'(acc_new >> SHIFT);

  always_ff @(posedge clock or posedge rst) begin
    if (rst)                 alarm <= '0;
    else if (state == FILTER) alarm[idx] <= (new_out >= 12'(ALARM_LEVEL));
  end
`endif

endmodule
